// File: rtl/seg7_pkg.sv
// Shared types, glyph table and load-value clamp for the 7-segment counter array.
package seg7_pkg;

  typedef logic [7:0] seg7_t;   // {dp,g,f,e,d,c,b,a}
  typedef logic [3:0] digit_t;

  // Active-high glyphs 0-9 then A,b,C,d,E,F; dp (bit 7) always off.
  localparam seg7_t SEG7_GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  // Preset digits outside the radix are pinned to the largest legal digit.
  function automatic digit_t clamp_digit(input digit_t d, input int base);
    int dv;
    dv = int'(d);
    return (dv >= base) ? digit_t'(base - 1) : d;
  endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational digit-to-segment decoder with selectable output polarity.
module seg7_glyph_dec
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  digit_t i_digit,
  output seg7_t  o_seg
);

  assign o_seg = ACTIVE_LOW ? ~SEG7_GLYPH[i_digit] : SEG7_GLYPH[i_digit];

endmodule

// File: rtl/seg7_counter_array.sv
// N-digit base-10/16 counter with tick prescaler, single-cycle carry chain,
// up/down, clear, preset load, wrap pulse and registered 7-segment outputs.
module seg7_counter_array
  import seg7_pkg::*;
#(
  parameter int FREQUENCY      = 50 * 10**6,
  parameter int TICK_HZ        = 1,
  parameter int NUM_DIGITS     = 2,
  parameter int BASE           = 10,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [8*NUM_DIGITS-1:0] seg7led,
  output logic                    tick,
  output logic                    wrap
);

  localparam int     DIV       = FREQUENCY / TICK_HZ;
  localparam int     PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam digit_t MAX_D     = digit_t'(BASE - 1);
  localparam seg7_t  ZERO_SEG  = (SEG_ACTIVE_LOW != 0) ? ~SEG7_GLYPH[0] : SEG7_GLYPH[0];

  if (DIV < 1) begin : g_bad_div
    $error("seg7_counter_array: FREQUENCY/TICK_HZ must be >= 1");
  end
  if (BASE != 10 && BASE != 16) begin : g_bad_base
    $error("seg7_counter_array: BASE must be 10 or 16");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_counter_array: NUM_DIGITS must be 1..8");
  end

  logic [PW-1:0]           r_presc;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [8*NUM_DIGITS-1:0] r_seg;
  logic                    r_tick;
  logic                    r_wrap;

  logic                    w_step;
  logic [4*NUM_DIGITS-1:0] w_next_val;
  logic [8*NUM_DIGITS-1:0] w_seg_all;
  logic                    w_next_tick;
  logic                    w_next_wrap;
  logic                    w_carry;

  assign w_step = en && (r_presc == PRESC_MAX);

  // Prescaler: free-runs while enabled, restarts on reset, clear or load.
  always_ff @(posedge clk) begin
    if (rst || clr || load) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    end
  end

  // Next digit state: clear > load > step, carry/borrow resolved across all digits at once.
  always_comb begin
    w_next_val  = r_digits;
    w_next_tick = 1'b0;
    w_next_wrap = 1'b0;
    w_carry     = 1'b1;
    if (clr) begin
      w_next_val = '0;
    end else if (load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        w_next_val[4*i +: 4] = clamp_digit(load_val[4*i +: 4], BASE);
      end
    end else if (w_step) begin
      w_next_tick = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_carry) begin
          if (!dir) begin
            if (r_digits[4*i +: 4] == MAX_D) begin
              w_next_val[4*i +: 4] = '0;
            end else begin
              w_next_val[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
              w_carry              = 1'b0;
            end
          end else begin
            if (r_digits[4*i +: 4] == '0) begin
              w_next_val[4*i +: 4] = MAX_D;
            end else begin
              w_next_val[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
              w_carry              = 1'b0;
            end
          end
        end
      end
      // Carry out of the top digit means every digit rolled over.
      w_next_wrap = w_carry;
    end
  end

  // Decode the next digit values so segments land on the same edge as digit_val.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    seg7_glyph_dec #(
      .ACTIVE_LOW(SEG_ACTIVE_LOW != 0)
    ) u_dec (
      .i_digit(w_next_val[4*gi +: 4]),
      .o_seg  (w_seg_all[8*gi +: 8])
    );
  end

  // Output registers: digits, segments and the tick/wrap pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
      r_seg    <= {NUM_DIGITS{ZERO_SEG}};
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_digits <= w_next_val;
      r_seg    <= w_seg_all;
      r_tick   <= w_next_tick;
      r_wrap   <= w_next_wrap;
    end
  end

  assign digit_val = r_digits;
  assign seg7led   = r_seg;
  assign tick      = r_tick;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_seg7_counter_array.sv
// Scoreboard bench: a decimal (active-low) and a hex (active-high) instance
// share stimulus; an integer reference model predicts each edge's outputs.
module tb_seg7_counter_array;

  logic        clk = 1'b0;
  logic        rst, en, dir, clr, load;
  logic [7:0]  load_val;
  logic [7:0]  dv10, dv16;
  logic [15:0] seg10, seg16;
  logic        tick10, wrap10, tick16, wrap16;

  always #5 clk = ~clk;

  seg7_counter_array #(
    .FREQUENCY(20), .TICK_HZ(2), .NUM_DIGITS(2), .BASE(10), .SEG_ACTIVE_LOW(1)
  ) u_dec10 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .digit_val(dv10), .seg7led(seg10),
    .tick(tick10), .wrap(wrap10)
  );

  seg7_counter_array #(
    .FREQUENCY(20), .TICK_HZ(2), .NUM_DIGITS(2), .BASE(16), .SEG_ACTIVE_LOW(0)
  ) u_hex16 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .digit_val(dv16), .seg7led(seg16),
    .tick(tick16), .wrap(wrap16)
  );

  // Common-anode glyph codes as read off a display datasheet.
  localparam logic [7:0] GLYPH_AL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [7:0]  dv10;
    logic [15:0] seg10;
    logic        t10, w10;
    logic [7:0]  dv16;
    logic [15:0] seg16;
    logic        t16, w16;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_cnt10 = 0;
  int   m_cnt16 = 0;
  int   m_presc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the coming edge.
  task automatic cyc(input logic r, input logic e, input logic d, input logic c,
                     input logic l, input logic [7:0] lv);
    exp_t x;
    int   hi, lo;
    logic t, w10, w16;
    @(negedge clk);
    rst = r; en = e; dir = d; clr = c; load = l; load_val = lv;
    t = 1'b0; w10 = 1'b0; w16 = 1'b0;
    if (r || c) begin
      m_cnt10 = 0; m_cnt16 = 0; m_presc = 0;
    end else if (l) begin
      hi = int'(lv[7:4]); lo = int'(lv[3:0]);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      m_cnt10 = hi * 10 + lo;
      m_cnt16 = int'(lv);
      m_presc = 0;
    end else if (e) begin
      if (m_presc == 9) begin
        m_presc = 0;
        t = 1'b1;
        if (!d) begin
          w10 = (m_cnt10 == 99); w16 = (m_cnt16 == 255);
          m_cnt10 = (m_cnt10 + 1) % 100; m_cnt16 = (m_cnt16 + 1) % 256;
        end else begin
          w10 = (m_cnt10 == 0); w16 = (m_cnt16 == 0);
          m_cnt10 = (m_cnt10 + 99) % 100; m_cnt16 = (m_cnt16 + 255) % 256;
        end
      end else begin
        m_presc++;
      end
    end
    x.dv10  = {4'(m_cnt10 / 10), 4'(m_cnt10 % 10)};
    x.seg10 = {GLYPH_AL[m_cnt10 / 10], GLYPH_AL[m_cnt10 % 10]};
    x.t10   = t;
    x.w10   = w10;
    x.dv16  = 8'(m_cnt16);
    x.seg16 = ~{GLYPH_AL[m_cnt16 / 16], GLYPH_AL[m_cnt16 % 16]};
    x.t16   = t;
    x.w16   = w16;
    sb.push_back(x);
  endtask

  // Monitor: just after each edge, pop one prediction and compare both instances.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("dv10",   dv10,   e.dv10);
      check("seg10",  seg10,  e.seg10);
      check("tick10", tick10, e.t10);
      check("wrap10", wrap10, e.w10);
      check("dv16",   dv16,   e.dv16);
      check("seg16",  seg16,  e.seg16);
      check("tick16", tick16, e.t16);
      check("wrap16", wrap16, e.w16);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;

    repeat (2) cyc(1, 0, 0, 0, 0, 8'h00);
    check("rst_seg10", seg10, 16'hC0C0);
    check("rst_seg16", seg16, 16'h3F3F);
    check("rst_dv10",  dv10,  8'h00);

    // Full decimal up count through 99 -> 00.
    repeat (1005) cyc(0, 1, 0, 0, 0, 8'h00);

    // Down wrap from 00.
    cyc(0, 0, 1, 0, 1, 8'h00);
    repeat (25) cyc(0, 1, 1, 0, 0, 8'h00);

    // Hex carries and wrap; decimal instance sees clamped presets.
    cyc(0, 0, 0, 0, 1, 8'h0F);
    repeat (12) cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'hFF);
    repeat (12) cyc(0, 1, 0, 0, 0, 8'h00);

    // Load in a step cycle: clamp, no tick, prescaler restarts.
    for (int k = 0; k < 20 && m_presc != 9; k++) cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 1, 8'hC7);
    repeat (12) cyc(0, 1, 0, 0, 0, 8'h00);

    // Pause mid-interval, then resume.
    repeat (4)  cyc(0, 1, 0, 0, 0, 8'h00);
    repeat (25) cyc(0, 0, 0, 0, 0, 8'h00);
    repeat (8)  cyc(0, 1, 0, 0, 0, 8'h00);

    // Clear beats load.
    cyc(0, 1, 0, 1, 1, 8'h55);
    repeat (12) cyc(0, 1, 0, 0, 0, 8'h00);

    // Direction flips mid-interval.
    repeat (5)  cyc(0, 1, 0, 0, 0, 8'h00);
    repeat (12) cyc(0, 1, 1, 0, 0, 8'h00);

    // Segment check on 0x80.
    cyc(0, 0, 0, 0, 1, 8'h80);
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("seg_80", seg10, 16'h80C0);
    check("dv_80",  dv10,  8'h80);

    // Randomised mix of controls.
    repeat (300) cyc(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 30) == 0),
                     8'($urandom));

    // Reset mid-interval; first tick DIV cycles after release.
    repeat (3) cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 0, 8'h00);
    repeat (12) cyc(0, 1, 0, 0, 0, 8'h00);

    repeat (2) cyc(0, 0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_counter_array.md
Name: seg7_counter_array

Overview:
- Parametrised successor to the fixed two-digit seconds counter and display path: N-digit counter in base 10 or 16 with an internal tick prescaler, carry chain and 7-segment decode.
- Adds up/down counting, run/pause, synchronous clear, parallel preset load, a wrap pulse and selectable segment polarity.
- Sits between board switches/buttons and the 7-seg/LED pins in the top level.
- Replaces the per-digit counter instances and the shared decoder.

Parameters:
- FREQUENCY, 50*10**6, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = FREQUENCY/TICK_HZ; elaboration error if DIV < 1.
- NUM_DIGITS, 2, number of digits, range 1..8.
- BASE, 10, digit radix; only 10 or 16 are legal (elaboration error otherwise).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted, for common-anode displays.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = prescaler and counter run; 0 = both hold
- dir  in  1  0 = count up, 1 = count down
- clr  in  1  synchronous clear of counter and prescaler
- load  in  1  synchronous load of load_val
- load_val  in  4*NUM_DIGITS  preset value; digit i is [4i+3:4i]
- digit_val  out  4*NUM_DIGITS  current digit values, same packing as load_val
- seg7led  out  8*NUM_DIGITS  segment bits per digit, bits [8i+7:8i] = {dp,g,f,e,d,c,b,a}
- tick  out  1  one-cycle pulse at each count step
- wrap  out  1  one-cycle pulse when the counter wraps

Behaviour:
- Reset (rst=1 at clk edge):
  - prescaler = 0, all digits = 0, tick = 0, wrap = 0.
  - seg7led = the "0" pattern with dp off, after polarity is applied.
- Prescaler:
  - Counts 0..DIV-1 while en=1, wraps to 0. Holds its value while en=0.
  - Internal step strobe is asserted in the cycle where prescaler == DIV-1 and en=1.
  - tick is a registered copy of the step strobe, so it is high in the same cycle the new digit_val appears.
- Priority per cycle: rst > clr > load > step > hold.
- clr: digits = 0, prescaler = 0, wrap = 0. An in-flight step is discarded.
- load:
  - Digit i = load_val digit i; any value >= BASE is clamped to BASE-1.
  - Prescaler = 0. No wrap pulse.
- Step, counting up:
  - Digit 0 increments.
  - Digit i (i>0) increments only if every lower digit equals BASE-1.
  - A digit at BASE-1 that increments becomes 0.
- Step, counting down:
  - Digit 0 decrements.
  - Digit i decrements only if every lower digit equals 0.
  - A digit at 0 that decrements becomes BASE-1.
- Carry is computed combinationally across all digits in the same cycle. No ripple delay; all digits update on one edge.
- wrap:
  - Registered pulse, high for exactly one cycle, coincident with tick.
  - Up: fires when the step moves all-(BASE-1) to all-0.
  - Down: fires when the step moves all-0 to all-(BASE-1).
- dir is sampled in the step cycle only. Changing dir mid-interval just takes effect at the next step.
- seg7led:
  - Registered decode of the next digit_val, so it is cycle-aligned with digit_val (zero extra latency).
  - Glyphs 0-9 are standard. A-F give A,b,C,d,E,F; these only occur when BASE=16.
  - dp is always off.
  - When SEG_ACTIVE_LOW=1, all 8 bits are inverted.
- Reset mid-interval: prescaler restarts at 0; the first tick comes DIV cycles after rst deasserts with en=1.
- load and step in the same cycle: load wins, no tick, no wrap.

Decomposition:
- Package seg7_pkg:
  - SEG7_GLYPH[16] constant table (active-high, {dp,g..a}).
  - seg7_t typedef (logic [7:0]).
  - digit_t typedef (logic [3:0]).
  - A clamp function for load values.
- Sub-module seg7_glyph_dec: combinational, digit_t in, seg7_t out, with polarity parameter. Instantiated NUM_DIGITS times in a generate loop.
- Counter, carry chain and prescaler stay in seg7_counter_array.

Test Plan:
- Base decimal count: FREQUENCY=20, TICK_HZ=2 (DIV=10), NUM_DIGITS=2, BASE=10; rst then en=1, dir=0.
  - tick every 10 cycles.
  - digit_val goes 0x00 → 0x09 → 0x10 after 10 ticks.
  - After the 100th tick, 0x99 → 0x00 with wrap=1 for one cycle.
- Down wrap: same config, load 0x00 then dir=1.
  - Next tick gives 0x99, wrap=1.
  - Following tick gives 0x98, wrap=0.
- Hex mode: BASE=16, load 0x0F, dir=0 → next tick 0x10; load 0xFF → next tick 0x00, wrap=1.
- Load clamp and priority: BASE=10, load_val 0xC7 asserted in a step cycle → digit_val 0x97, no tick, no wrap, prescaler restarts (next tick 10 cycles later).
- Pause and clear:
  - en=0 for 25 cycles → digit_val and prescaler frozen, no tick.
  - clr asserted together with load → digit_val 0x00.
- Segment decode, SEG_ACTIVE_LOW=1:
  - digit_val 0x80 → seg7led[15:8] = 8'h80 (inverted 7F), seg7led[7:0] = 8'hC0 (inverted 3F).
  - After rst, both digits show 8'hC0.
